// File: rtl/board_state_if.sv
// Lock request/completion bus between a piece controller (master) and the board (slave).
interface board_state_if #(
    parameter int POS_W = 8
);
    logic             lock_valid;
    logic             lock_ready;
    logic [POS_W-1:0] blk_1;
    logic [POS_W-1:0] blk_2;
    logic [POS_W-1:0] blk_3;
    logic [POS_W-1:0] blk_4;
    logic             done;
    logic [2:0]       lines_cleared;

    modport master (
        output lock_valid, blk_1, blk_2, blk_3, blk_4,
        input  lock_ready, done, lines_cleared
    );

    modport slave (
        input  lock_valid, blk_1, blk_2, blk_3, blk_4,
        output lock_ready, done, lines_cleared
    );
endinterface

// File: rtl/board_state.sv
// Tetris board occupancy: locks a 4-cell piece, then scans bottom-up and collapses full rows.
module board_state #(
    parameter int W     = 10,
    parameter int H     = 20,
    parameter int POS_W = 8
) (
    input  logic               dclk,
    input  logic               clr_n,
    board_state_if.slave       lk,
    input  logic               clear_board,
    output logic [W*H-1:0]     placed_tetrominos,
    output logic [15:0]        total_lines,
    output logic               overlap
);
    localparam int N  = W * H;
    localparam int RW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [2:0] {IDLE, WRITE, SCAN, SHIFT, DONE} state_t;

    state_t                  state, state_nx;
    logic [3:0][POS_W-1:0]   blk_q;
    logic [RW-1:0]           row;
    logic [2:0]              cnt;
    logic [N-1:0]            set_mask;
    logic [N-1:0]            shift_brd;
    logic                    row_full;
    logic                    hit;
    logic                    accept;

    // Out-of-range indices simply never match any cell, so they drop out of the mask.
    always_comb begin
        set_mask = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < N; j++)
                if (int'(blk_q[i]) == j) set_mask[j] = 1'b1;
    end

    assign hit      = |(set_mask & placed_tetrominos);
    assign row_full = &placed_tetrominos[int'(row)*W +: W];

    always_comb begin
        shift_brd = placed_tetrominos;
        for (int y = 0; y < H; y++)
            if (y == 0)
                shift_brd[0 +: W] = '0;
            else if (y <= int'(row))
                shift_brd[y*W +: W] = placed_tetrominos[(y-1)*W +: W];
    end

    always_ff @(posedge dclk or negedge clr_n)
        if (!clr_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = WRITE;
            WRITE:   state_nx = SCAN;
            SCAN:    if (row_full)      state_nx = SHIFT;
                     else if (row == '0) state_nx = DONE;
            SHIFT:   state_nx = SCAN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        lk.lock_ready = (state == IDLE) && !clear_board;
        accept        = lk.lock_ready && lk.lock_valid;
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            placed_tetrominos <= '0;
            blk_q             <= '0;
            row               <= RW'(H - 1);
            cnt               <= '0;
            total_lines       <= '0;
            overlap           <= 1'b0;
            lk.done           <= 1'b0;
            lk.lines_cleared  <= '0;
        end else begin
            // done is registered so it lands one cycle after the DONE state.
            lk.done <= (state == DONE);
            if (state == DONE) lk.lines_cleared <= cnt;
            case (state)
                IDLE: begin
                    if (clear_board) begin
                        placed_tetrominos <= '0;
                        overlap           <= 1'b0;
                    end else if (lk.lock_valid) begin
                        blk_q <= {lk.blk_4, lk.blk_3, lk.blk_2, lk.blk_1};
                    end
                end
                WRITE: begin
                    placed_tetrominos <= placed_tetrominos | set_mask;
                    if (hit) overlap <= 1'b1;
                    row <= RW'(H - 1);
                    cnt <= '0;
                end
                SCAN:  if (!row_full && row != '0) row <= row - 1'b1;
                SHIFT: begin
                    placed_tetrominos <= shift_brd;
                    cnt <= cnt + 1'b1;
                    if (total_lines != 16'hffff) total_lines <= total_lines + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_board_state.sv
// Scoreboard bench for board_state: a row-collapse model predicts each lock's outcome.
module tb_board_state;
    localparam int W = 10, H = 20, POS_W = 8, N = W * H;

    logic           dclk = 1'b0;
    logic           clr_n = 1'b0;
    logic           clear_board = 1'b0;
    logic [N-1:0]   placed;
    logic [15:0]    total;
    logic           ovl;

    board_state_if #(.POS_W(POS_W)) bus();

    board_state #(.W(W), .H(H), .POS_W(POS_W)) dut (
        .dclk              (dclk),
        .clr_n             (clr_n),
        .lk                (bus.slave),
        .clear_board       (clear_board),
        .placed_tetrominos (placed),
        .total_lines       (total),
        .overlap           (ovl)
    );

    always #5 dclk = ~dclk;

    int cyc = 0;
    always @(posedge dclk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]   lc;
        logic [N-1:0] brd;
        logic [15:0]  tot;
        logic         ovl;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] m_brd = '0;
    logic [15:0]  m_tot = '0;
    logic         m_ovl = 1'b0;
    int           n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Independent model: rebuild the board from non-full rows, packed to the bottom.
    function automatic int collapse(input logic [N-1:0] b, output logic [N-1:0] nb);
        int ny = H - 1;
        int lc = 0;
        nb = '0;
        for (int y = H - 1; y >= 0; y--) begin
            if (&b[y*W +: W]) lc++;
            else begin
                nb[ny*W +: W] = b[y*W +: W];
                ny--;
            end
        end
        return lc;
    endfunction

    task automatic do_lock(input int a, input int b, input int c, input int d);
        exp_t         e;
        int           idx[4];
        logic [N-1:0] nb;
        int           n, hs, lc;
        idx = '{a, b, c, d};
        for (int i = 0; i < 4; i++) if (idx[i] < N && m_brd[idx[i]]) m_ovl = 1'b1;
        for (int i = 0; i < 4; i++) if (idx[i] < N) m_brd[idx[i]] = 1'b1;
        lc    = collapse(m_brd, nb);
        m_brd = nb;
        m_tot = (int'(m_tot) + lc > 65535) ? 16'hffff : m_tot + 16'(lc);
        e.lc  = 3'(lc);
        e.brd = m_brd;
        e.tot = m_tot;
        e.ovl = m_ovl;
        e.lat = H + 2 + 2 * lc;
        sb.push_back(e);

        @(negedge dclk);
        bus.lock_valid = 1'b1;
        bus.blk_1 = POS_W'(a);
        bus.blk_2 = POS_W'(b);
        bus.blk_3 = POS_W'(c);
        bus.blk_4 = POS_W'(d);
        n = 0;
        while (!bus.lock_ready && n < 50) begin @(negedge dclk); n++; end
        if (!bus.lock_ready) chk("ready_timeout", N'(bus.lock_ready), N'(1));
        hs = cyc + 1;
        @(negedge dclk);
        bus.lock_valid = 1'b0;
        n = 0;
        while (!bus.done && n < 100) begin @(negedge dclk); n++; end
        e = sb.pop_front();
        if (!bus.done) chk("done_timeout", N'(bus.done), N'(1));
        else begin
            chk("lines_cleared", N'(bus.lines_cleared), N'(e.lc));
            chk("board",         placed,                e.brd);
            chk("total_lines",   N'(total),             N'(e.tot));
            chk("overlap",       N'(ovl),               N'(e.ovl));
            chk("latency",       N'(cyc - hs),          N'(e.lat));
        end
        @(negedge dclk);
        chk("done_pulse", N'(bus.done), N'(0));
    endtask

    task automatic do_clear();
        @(negedge dclk);
        clear_board = 1'b1;
        @(negedge dclk);
        clear_board = 1'b0;
        m_brd = '0;
        m_ovl = 1'b0;
        chk("clr_board",   placed, m_brd);
        chk("clr_overlap", N'(ovl), N'(m_ovl));
    endtask

    task automatic count_done(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge dclk);
            if (bus.done) hits++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        bus.lock_valid = 1'b0;
        bus.blk_1 = '0; bus.blk_2 = '0; bus.blk_3 = '0; bus.blk_4 = '0;
        repeat (3) @(negedge dclk);
        clr_n = 1'b1;
        @(negedge dclk);
        chk("rst_board",  placed,                   '0);
        chk("rst_total",  N'(total),                N'(0));
        chk("rst_ovl",    N'(ovl),                  N'(0));
        chk("rst_ready",  N'(bus.lock_ready),       N'(1));
        chk("rst_done",   N'(bus.done),             N'(0));
        chk("rst_lc",     N'(bus.lines_cleared),    N'(0));

        // Single piece on the bottom row, no clears.
        do_lock(190, 191, 192, 193);
        // One full row at the bottom, with a marker in row 0 that must drop one row.
        do_lock(194, 195, 5, 250);
        do_lock(196, 197, 198, 199);

        // Four rows full except column 9, closed by a vertical I piece.
        do_clear();
        for (int k = 0; k < 9; k++) begin
            int c[4];
            for (int j = 0; j < 4; j++) c[j] = ((4*k + j) % 9) + (16 + (4*k + j) / 9) * W;
            do_lock(c[0], c[1], c[2], c[3]);
        end
        do_lock(169, 179, 189, 199);

        // Duplicate and out-of-range indices, then an overlapping relock.
        do_clear();
        do_lock(5, 5, 200, 250);
        do_lock(5, 6, 7, 8);
        do_clear();

        // Wipe wins over a concurrent lock request.
        @(negedge dclk);
        clear_board = 1'b1;
        bus.lock_valid = 1'b1;
        bus.blk_1 = 8'd1; bus.blk_2 = 8'd2; bus.blk_3 = 8'd3; bus.blk_4 = 8'd4;
        #1;
        chk("clr_blocks_ready", N'(bus.lock_ready), N'(0));
        @(negedge dclk);
        clear_board = 1'b0;
        bus.lock_valid = 1'b0;
        count_done(30, hits);
        chk("clr_no_lock_done",  N'(hits), N'(0));
        chk("clr_no_lock_board", placed,   '0);

        // Reset mid-SHIFT abandons the lock.
        do_lock(190, 191, 192, 193);
        do_lock(194, 195, 250, 250);
        @(negedge dclk);
        bus.lock_valid = 1'b1;
        bus.blk_1 = 8'd196; bus.blk_2 = 8'd197; bus.blk_3 = 8'd198; bus.blk_4 = 8'd199;
        hits = 0;
        while (!bus.lock_ready && hits < 50) begin @(negedge dclk); hits++; end
        @(negedge dclk);
        bus.lock_valid = 1'b0;
        repeat (2) @(negedge dclk);
        clr_n = 1'b0;
        #1;
        chk("mid_rst_board", placed,                '0);
        chk("mid_rst_total", N'(total),             N'(0));
        chk("mid_rst_ovl",   N'(ovl),               N'(0));
        chk("mid_rst_done",  N'(bus.done),          N'(0));
        chk("mid_rst_lc",    N'(bus.lines_cleared), N'(0));
        @(negedge dclk);
        clr_n = 1'b1;
        count_done(30, hits);
        chk("mid_rst_no_done", N'(hits),           N'(0));
        chk("mid_rst_ready",   N'(bus.lock_ready), N'(1));
        chk("mid_rst_board2",  placed,             '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
